// File: rtl/dma_copy_engine.sv
// Memory-to-memory block-copy DMA initiator with one outstanding request at a time.
// Optional per-request watchdog is enabled by defining DMA_TIMEOUT_EN.
module dma_copy_engine #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 28,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

  state_t                state;
  logic                  req_q;
  logic                  abort_pend;
  logic [ADDR_WIDTH-1:0] cur_src;
  logic [ADDR_WIDTH-1:0] cur_dst;
  logic [LEN_WIDTH-1:0]  remaining;

`ifdef DMA_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // An abort seen in a request cycle suppresses the strobe of that same cycle.
  assign mem_en = req_q & ~abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      abort_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      words_done <= '0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cur_src    <= '0;
      cur_dst    <= '0;
      remaining  <= '0;
`ifdef DMA_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cur_src    <= src_addr;
          cur_dst    <= dst_addr;
          remaining  <= len;
          err        <= 1'b0;
          words_done <= '0;
          abort_pend <= 1'b0;
          if (len == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= RD_REQ;
            busy      <= 1'b1;
            req_q     <= 1'b1;
            mem_wr_en <= 1'b0;
            mem_addr  <= src_addr;
          end
        end
        RD_REQ, WR_REQ: begin
          req_q <= 1'b0;
`ifdef DMA_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          if (abort) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= (state == RD_REQ) ? RD_WAIT : WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (abort) abort_pend <= 1'b1;
          if (mem_valid) begin
            mem_wdata <= mem_rdata;
            cur_src   <= cur_src + ADDR_WIDTH'(1);
            if (abort || abort_pend) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state     <= WR_REQ;
              req_q     <= 1'b1;
              mem_wr_en <= 1'b1;
              mem_addr  <= cur_dst;
            end
          end
`ifdef DMA_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        WR_WAIT: begin
          if (abort) abort_pend <= 1'b1;
          if (mem_valid) begin
            cur_dst    <= cur_dst + ADDR_WIDTH'(1);
            words_done <= words_done + LEN_WIDTH'(1);
            remaining  <= remaining - LEN_WIDTH'(1);
            if (abort || abort_pend || remaining == LEN_WIDTH'(1)) begin
              err   <= abort || abort_pend;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state     <= RD_REQ;
              req_q     <= 1'b1;
              mem_wr_en <= 1'b0;
              mem_addr  <= cur_src;
            end
          end
`ifdef DMA_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a behavioural memory controller of programmable latency.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [27:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, err;
  logic [15:0] words_done;
  logic        mem_en, mem_wr_en;
  logic [27:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_valid;

  int vectors = 0;
  int miscompares = 0;

  dma_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .abort(abort), .busy(busy), .done(done), .err(err),
    .words_done(words_done), .mem_en(mem_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  // Controller model: valid arrives lat cycles after the request cycle.
  logic [31:0] mem [logic [27:0]];
  logic [27:0] rd_q [$];
  int          lat = 1;
  int          en_cnt, rd_cnt, wr_cnt, dbl_cnt, rem;
  logic        pend, p_wr, prev_en;
  logic [27:0] p_addr;
  logic [31:0] p_data;

  initial begin
    mem_valid = 1'b0; mem_rdata = '0; pend = 1'b0; prev_en = 1'b0;
    en_cnt = 0; rd_cnt = 0; wr_cnt = 0; dbl_cnt = 0; rem = 0;
  end

  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
      prev_en = 1'b0;
    end else begin
      if (pend) begin
        rem--;
        if (rem == 0) begin
          pend = 1'b0;
          mem_valid = 1'b1;
          if (p_wr) begin
            mem[p_addr] = p_data;
            wr_cnt++;
          end else begin
            mem_rdata = mem.exists(p_addr) ? mem[p_addr] : 32'hDEAD_BEEF;
          end
        end
      end
      if (mem_en) begin
        en_cnt++;
        if (prev_en) dbl_cnt++;
        pend = 1'b1; rem = lat; p_wr = mem_wr_en; p_addr = mem_addr; p_data = mem_wdata;
        if (!mem_wr_en) begin
          rd_cnt++;
          rd_q.push_back(mem_addr);
        end
      end
      prev_en = mem_en;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int  cyc;
  bit  busy_seen;

  // Starts a transfer; cyc = cycles from the accepting edge to the done pulse (-1 if never).
  task automatic run(input logic [27:0] s, input logic [27:0] d, input logic [15:0] n,
                     input int abort_at, input int rst_at);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    en_cnt = 0; rd_cnt = 0; wr_cnt = 0; dbl_cnt = 0; rd_q.delete();
    @(posedge clk);
    #1 start = 1'b0;
    cyc = -1; busy_seen = 1'b0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      abort = (i == abort_at);
      if (i == rst_at) begin
        rst = 1'b1;
        cyc = 0;
        break;
      end
      if (busy) busy_seen = 1'b1;
      if (done) begin
        cyc = i;
        break;
      end
    end
    abort = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_words"}, words_done, 0);
    chk({tag, "_en"}, mem_en, 0);
    chk({tag, "_wr"}, mem_wr_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    mem[28'h100] = 32'hA0; mem[28'h101] = 32'hA1; mem[28'h102] = 32'hA2; mem[28'h103] = 32'hA3;
    mem[28'h110] = 32'h5A5A0001; mem[28'h111] = 32'h5A5A0002;
    for (int i = 0; i < 8; i++) mem[28'h120 + 28'(i)] = 32'hB000 + 32'(i);
    mem[28'hFFFFFFF] = 32'hCAFE0000; mem[28'h0] = 32'hCAFE0001;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Basic copy, valid one cycle after each request: done at 1+4*4.
    lat = 1;
    run(28'h100, 28'h200, 16'd4, 0, 0);
    chk("basic_cycles", cyc, 17);
    chk("basic_words", words_done, 4);
    chk("basic_err", err, 0);
    chk("basic_en_cnt", en_cnt, 8);
    chk("basic_d0", mem[28'h200], 32'hA0);
    chk("basic_d1", mem[28'h201], 32'hA1);
    chk("basic_d2", mem[28'h202], 32'hA2);
    chk("basic_d3", mem[28'h203], 32'hA3);
    @(negedge clk);
    chk("basic_done_1cyc", done, 0);
    chk("basic_busy_after", busy, 0);

    // Zero length: done on the cycle after start, no traffic.
    run(28'h100, 28'h280, 16'd0, 0, 0);
    chk("zero_cycles", cyc, 1);
    chk("zero_en_cnt", en_cnt, 0);
    chk("zero_busy_seen", busy_seen, 0);

    // Contention: valid 3 cycles late on every request, 4 requests -> +12.
    lat = 4;
    run(28'h110, 28'h210, 16'd2, 0, 0);
    chk("cont_cycles", cyc, 21);
    chk("cont_en_cnt", en_cnt, 4);
    chk("cont_en_width", dbl_cnt, 0);
    chk("cont_d0", mem[28'h210], 32'h5A5A0001);
    chk("cont_d1", mem[28'h211], 32'h5A5A0002);

    // Abort during the third RD_WAIT (cycle 10): read completes, no third write.
    lat = 1;
    run(28'h120, 28'h220, 16'd8, 10, 0);
    chk("abort_cycles", cyc, 11);
    chk("abort_err", err, 1);
    chk("abort_words", words_done, 2);
    chk("abort_reads", rd_cnt, 3);
    chk("abort_writes", wr_cnt, 2);
    chk("abort_no_w2", mem.exists(28'h222), 0);
    chk("abort_d1", mem[28'h221], 32'hB001);
    @(negedge clk);
    chk("abort_err_sticky", err, 1);

    // A new start clears err.
    run(28'h100, 28'h230, 16'd1, 0, 0);
    chk("restart_cycles", cyc, 5);
    chk("restart_err", err, 0);
    chk("restart_words", words_done, 1);
    chk("restart_d0", mem[28'h230], 32'hA0);

    // Source address wrap.
    run(28'hFFFFFFF, 28'h240, 16'd2, 0, 0);
    chk("wrap_cycles", cyc, 9);
    chk("wrap_rd_cnt", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      chk("wrap_rd0", rd_q[0], 28'hFFFFFFF);
      chk("wrap_rd1", rd_q[1], 28'h0);
    end
    chk("wrap_d0", mem[28'h240], 32'hCAFE0000);
    chk("wrap_d1", mem[28'h241], 32'hCAFE0001);

    // Reset in the middle of the first WR_WAIT (cycles 13..22 with lat=10).
    lat = 10;
    run(28'h100, 28'h250, 16'd2, 0, 14);
    chk("rst_midwait_reached", cyc, 0);
    @(posedge clk);
    #1 chk_all_zero("rst_mid");
    @(negedge clk) rst = 1'b0;
    lat = 1;
    run(28'h101, 28'h260, 16'd1, 0, 0);
    chk("post_rst_cycles", cyc, 5);
    chk("post_rst_d0", mem[28'h260], 32'hA1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
